// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the data memory responder.
// Holds the responder FSM state type, the data word width, the wait-state
// counter width and the default memory map constants.
package mem_pkg;

    localparam int          WORD_W          = 32;
    localparam int          CNT_W           = 4;
    localparam logic [31:0] DEF_BASE_ADDR   = 32'h0000_0000;
    localparam int          DEF_DEPTH_WORDS = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/word_ram.sv
// word_ram: DEPTH_WORDS x WORD_W storage array, no reset.
// Write is synchronous (on posedge clk when we=1); the read port is a plain
// combinational lookup so the caller decides when to capture it.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   idx    in   word index
//   wdata  in   write data
//   rdata  out  data at idx
module word_ram
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    // Array write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory answering CPU load/store
// requests with a ready handshake after WAIT_STATES extra cycles.
// Optional build macro: MEM_ERR_EN enables access-fault reporting on err
// (misaligned, out of range, or simultaneous read+write); without it err is
// 0, address[1:0] is ignored and out-of-range indices wrap.
// Ports:
//   clk         in   clock
//   reset       in   asynchronous active-low reset
//   mem_read    in   load request (level, held until ready)
//   mem_write   in   store request (level, held until ready)
//   address     in   byte address
//   write_data  in   store data
//   read_data   out  load data, valid while ready=1 for a load
//   ready       out  one-cycle completion pulse
//   err         out  access fault, valid while ready=1
module data_mem_responder
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int          WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        err
);

    localparam int              IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WAIT_STATES);
`ifdef MEM_ERR_EN
    // One past the last valid byte address, kept 33 bits wide so a region
    // ending at the top of the address space does not overflow.
    localparam logic [32:0]     LIMIT   = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [WORD_W-1:0] read_data_q, read_data_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;

    logic              enter_resp_s;
    logic [31:0]       c_addr_s;
    logic [WORD_W-1:0] c_wdata_s;
    logic              c_rd_s;
    logic              c_wr_s;
    logic              fault_s;
    logic [IDX_W-1:0]  idx_s;
    logic              ram_we_s;
    logic [WORD_W-1:0] ram_rdata_s;

    // Next-state logic: request capture, wait countdown, single RESP cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    addr_d  = address;
                    wdata_d = write_data;
                    rd_d    = mem_read;
                    wr_d    = mem_write;
                    cnt_d   = WS_LOAD;
                    state_d = (WAIT_STATES == 0) ? RESP : WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // <= also recovers from a stray zero count.
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Commit decode. With zero wait states RESP is entered straight from IDLE
    // on the accepting edge, so the live request is the one being committed.
    always_comb begin
        enter_resp_s = (state_d == RESP) && (state_q != RESP);
        if (state_q == IDLE) begin
            c_addr_s  = address;
            c_wdata_s = write_data;
            c_rd_s    = mem_read;
            c_wr_s    = mem_write;
        end else begin
            c_addr_s  = addr_q;
            c_wdata_s = wdata_q;
            c_rd_s    = rd_q;
            c_wr_s    = wr_q;
        end
`ifdef MEM_ERR_EN
        fault_s = (c_addr_s[1:0] != 2'b00) ||
                  (c_addr_s < BASE_ADDR) ||
                  ({1'b0, c_addr_s} >= LIMIT) ||
                  (c_rd_s && c_wr_s);
`else
        fault_s = 1'b0;
`endif
        // Unsigned offset from the region base, truncated to the array index.
        idx_s       = IDX_W'((c_addr_s - BASE_ADDR) >> 2);
        ram_we_s    = enter_resp_s && c_wr_s && !fault_s;
        // A store wins over a simultaneous load, so the load capture needs !c_wr_s.
        if (enter_resp_s && c_rd_s && !c_wr_s && !fault_s) begin
            read_data_d = ram_rdata_s;
        end else begin
            read_data_d = read_data_q;
        end
        ready_d = enter_resp_s;
        err_d   = enter_resp_s && fault_s;
    end

    // State, request latch and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            read_data_q <= 32'h0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            read_data_q <= read_data_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
        end
    end

    word_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .idx   (idx_s),
        .wdata (c_wdata_s),
        .rdata (ram_rdata_s)
    );

    assign read_data = read_data_q;
    assign ready     = ready_q;
    assign err       = err_q;

endmodule
